// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: arbitrates NUM_RD read requesters onto one AXI read channel
// and serves one writeback/uncached-store requester on the AXI write channel.
module cache_axi_bridge #(
  parameter int NUM_RD     = 4,
  parameter int LINE_WORDS = 8,
  parameter int ARB_RR     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_req_i,
  input  logic [NUM_RD-1:0]          rd_single_i,
  input  logic [NUM_RD*32-1:0]       rd_addr_i,
  output logic [NUM_RD-1:0]          rd_done_o,
  output logic [LINE_WORDS*32-1:0]   rd_data_o,
  input  logic                       wr_req_i,
  input  logic                       wr_single_i,
  input  logic [31:0]                wr_addr_i,
  input  logic [LINE_WORDS*32-1:0]   wr_data_i,
  input  logic [3:0]                 wr_strb_i,
  output logic                       wr_busy_o,
  output logic                       wr_done_o,
  output logic                       m_arvalid_o,
  input  logic                       m_arready_i,
  output logic [31:0]                m_araddr_o,
  output logic [7:0]                 m_arlen_o,
  input  logic                       m_rvalid_i,
  output logic                       m_rready_o,
  input  logic [31:0]                m_rdata_i,
  input  logic                       m_rlast_i,
  output logic                       m_awvalid_o,
  input  logic                       m_awready_i,
  output logic [31:0]                m_awaddr_o,
  output logic [7:0]                 m_awlen_o,
  output logic                       m_wvalid_o,
  input  logic                       m_wready_i,
  output logic [31:0]                m_wdata_o,
  output logic [3:0]                 m_wstrb_o,
  output logic                       m_wlast_o,
  input  logic                       m_bvalid_i,
  output logic                       m_bready_o
);
  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = CW + 2;
  localparam int IW  = $clog2(NUM_RD);
  localparam logic [IW:0] NRW    = (IW+1)'(NUM_RD);
  localparam logic [CW:0] LW_CNT = (CW+1)'(LINE_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

  localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_B = 2'd3;

  function automatic logic [31:0] align(input logic [31:0] a, input logic single);
    return single ? a : {a[31:OFF], {OFF{1'b0}}};
  endfunction

  logic [NUM_RD-1:0][31:0]     rd_addr_w;
  logic [NUM_RD-1:0]           eligible;
  logic                        gnt_valid;
  logic [IW-1:0]               gnt_idx, ptr;
  logic [IW:0]                 p;

  logic [1:0]                  r_state_q, r_state_d;
  logic [IW-1:0]               r_idx_q, r_idx_d, rr_ptr_q, rr_ptr_d;
  logic [31:0]                 r_addr_q, r_addr_d;
  logic                        r_single_q, r_single_d;
  logic [CW:0]                 r_cnt_q, r_cnt_d;
  logic [LINE_WORDS-1:0][31:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]           rd_done_q, rd_done_d;

  logic [1:0]                  w_state_q, w_state_d;
  logic [31:0]                 w_addr_q, w_addr_d;
  logic [LINE_WORDS-1:0][31:0] w_data_q, w_data_d;
  logic [3:0]                  w_strb_q, w_strb_d;
  logic                        w_single_q, w_single_d;
  logic [CW-1:0]               w_cnt_q, w_cnt_d;
  logic                        wr_done_q, wr_done_d;

  assign rd_addr_w = rd_addr_i;
  assign wr_busy_o = (w_state_q != W_IDLE);

  // A read to the line currently being written must wait for the B response.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_elig
    assign eligible[k] = rd_req_i[k] &&
                         !(wr_busy_o && (rd_addr_w[k][31:OFF] == w_addr_q[31:OFF]));
  end

  // NOTE: every variable written in always_comb gets a default first, so no latches.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    p         = '0;
    ptr       = (ARB_RR != 0) ? rr_ptr_q : '0;
    for (int i = 0; i < NUM_RD; i++) begin
      p = {1'b0, ptr} + (IW+1)'(i);
      if (p >= NRW) p = p - NRW;
      if (!gnt_valid && eligible[p[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = p[IW-1:0];
      end
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_addr_d   = r_addr_q;
    r_single_d = r_single_q;
    r_cnt_d    = r_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    rd_data_d  = rd_data_q;
    rd_done_d  = '0;
    case (r_state_q)
      R_IDLE: if (gnt_valid) begin
        r_idx_d    = gnt_idx;
        r_single_d = rd_single_i[gnt_idx];
        r_addr_d   = align(rd_addr_w[gnt_idx], rd_single_i[gnt_idx]);
        r_cnt_d    = '0;
        rr_ptr_d   = ({1'b0, gnt_idx} == NRW - 1'b1) ? '0 : gnt_idx + 1'b1;
        r_state_d  = R_AR;
      end
      R_AR: if (m_arready_i) r_state_d = R_DATA;
      R_DATA: if (m_rvalid_i) begin
        // Beats beyond the line buffer are accepted but dropped.
        if (r_cnt_q < LW_CNT) begin
          rd_data_d[r_cnt_q[CW-1:0]] = m_rdata_i;
          r_cnt_d = r_cnt_q + 1'b1;
        end
        if (m_rlast_i) begin
          rd_done_d[r_idx_q] = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    w_single_d = w_single_q;
    w_cnt_d    = w_cnt_q;
    wr_done_d  = 1'b0;
    case (w_state_q)
      W_IDLE: if (wr_req_i) begin
        w_addr_d   = align(wr_addr_i, wr_single_i);
        w_data_d   = wr_data_i;
        w_strb_d   = wr_strb_i;
        w_single_d = wr_single_i;
        w_cnt_d    = '0;
        w_state_d  = W_AW;
      end
      W_AW:   if (m_awready_i) w_state_d = W_DATA;
      W_DATA: if (m_wready_i) begin
        if (m_wlast_o) w_state_d = W_B;
        else           w_cnt_d   = w_cnt_q + 1'b1;
      end
      W_B: if (m_bvalid_i) begin
        wr_done_d = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      rr_ptr_q  <= '0;
      rd_data_q <= '0;
      rd_done_q <= '0;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      wr_done_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      wr_done_q <= wr_done_d;
    end
  end

  // NOTE: payload registers are only consumed in non-idle states, so they carry no reset.
  always_ff @(posedge clk) begin
    r_idx_q    <= r_idx_d;
    r_addr_q   <= r_addr_d;
    r_single_q <= r_single_d;
    w_addr_q   <= w_addr_d;
    w_data_q   <= w_data_d;
    w_strb_q   <= w_strb_d;
    w_single_q <= w_single_d;
  end

  assign rd_done_o   = rd_done_q;
  assign rd_data_o   = rd_data_q;
  assign m_arvalid_o = (r_state_q == R_AR);
  assign m_araddr_o  = r_addr_q;
  assign m_arlen_o   = r_single_q ? 8'd0 : 8'(LINE_WORDS - 1);
  assign m_rready_o  = (r_state_q == R_DATA);

  assign wr_done_o   = wr_done_q;
  assign m_awvalid_o = (w_state_q == W_AW);
  assign m_awaddr_o  = w_addr_q;
  assign m_awlen_o   = w_single_q ? 8'd0 : 8'(LINE_WORDS - 1);
  assign m_wvalid_o  = (w_state_q == W_DATA);
  assign m_wdata_o   = w_data_q[w_cnt_q];
  assign m_wstrb_o   = w_single_q ? w_strb_q : 4'hF;
  assign m_wlast_o   = (w_state_q == W_DATA) && (w_cnt_q == (w_single_q ? '0 : LAST_WORD));
  assign m_bready_o  = (w_state_q == W_B);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed testbench for cache_axi_bridge: a fixed-priority and a round-robin instance
// share read requesters; each has its own AXI slave model driven on the falling edge.
module tb_cache_axi_bridge;
  localparam int NR = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [NR-1:0]      rd_req = '0, rd_single = '0;
  logic [NR*32-1:0]   rd_addr = '0;
  logic [NR-1:0]      rd_done [2];
  logic [LW*32-1:0]   rd_data [2];
  logic               arvalid [2], arready [2], rvalid [2], rready [2], rlast [2];
  logic [31:0]        araddr [2], rdata [2];
  logic [7:0]         arlen [2];

  logic               wr_req = 1'b0, wr_single = 1'b0;
  logic [31:0]        wr_addr = '0;
  logic [LW*32-1:0]   wr_data = '0;
  logic [3:0]         wr_strb = '0;
  logic               wr_busy, wr_done, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0]        awaddr, wdata;
  logic [7:0]         awlen;
  logic [3:0]         wstrb;

  logic               x_wr_busy, x_wr_done, x_awvalid, x_wvalid, x_wlast, x_bready;
  logic [31:0]        x_awaddr, x_wdata;
  logic [7:0]         x_awlen;
  logic [3:0]         x_wstrb;

  // Slave model state and controls
  logic        ar_en = 1'b1, aw_en = 1'b1, b_en = 1'b1, w_alt = 1'b0, w_tog = 1'b0;
  logic [31:0] rd_base = '0;
  int          rem [2], beat [2], ar_cnt [2];
  logic [31:0] last_araddr [2];
  logic [7:0]  last_arlen [2];
  int          rd_done_cnt [2][NR];
  int          aw_cnt = 0, w_beats = 0, b_cnt = 0, wr_done_cnt = 0;
  logic        b_pending = 1'b0;
  logic [31:0] last_awaddr = '0;
  logic [7:0]  last_awlen = '0;
  logic [31:0] wb_data [16];
  logic [3:0]  wb_strb [16];
  logic        wb_last [16];

  cache_axi_bridge #(.NUM_RD(NR), .LINE_WORDS(LW), .ARB_RR(0)) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req), .rd_single_i(rd_single), .rd_addr_i(rd_addr),
    .rd_done_o(rd_done[0]), .rd_data_o(rd_data[0]),
    .wr_req_i(wr_req), .wr_single_i(wr_single), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_busy_o(wr_busy), .wr_done_o(wr_done),
    .m_arvalid_o(arvalid[0]), .m_arready_i(arready[0]), .m_araddr_o(araddr[0]), .m_arlen_o(arlen[0]),
    .m_rvalid_i(rvalid[0]), .m_rready_o(rready[0]), .m_rdata_i(rdata[0]), .m_rlast_i(rlast[0]),
    .m_awvalid_o(awvalid), .m_awready_i(awready), .m_awaddr_o(awaddr), .m_awlen_o(awlen),
    .m_wvalid_o(wvalid), .m_wready_i(wready), .m_wdata_o(wdata), .m_wstrb_o(wstrb),
    .m_wlast_o(wlast), .m_bvalid_i(bvalid), .m_bready_o(bready)
  );

  cache_axi_bridge #(.NUM_RD(NR), .LINE_WORDS(LW), .ARB_RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req), .rd_single_i(rd_single), .rd_addr_i(rd_addr),
    .rd_done_o(rd_done[1]), .rd_data_o(rd_data[1]),
    .wr_req_i(1'b0), .wr_single_i(1'b0), .wr_addr_i(32'h0),
    .wr_data_i({(LW*32){1'b0}}), .wr_strb_i(4'h0), .wr_busy_o(x_wr_busy), .wr_done_o(x_wr_done),
    .m_arvalid_o(arvalid[1]), .m_arready_i(arready[1]), .m_araddr_o(araddr[1]), .m_arlen_o(arlen[1]),
    .m_rvalid_i(rvalid[1]), .m_rready_o(rready[1]), .m_rdata_i(rdata[1]), .m_rlast_i(rlast[1]),
    .m_awvalid_o(x_awvalid), .m_awready_i(1'b0), .m_awaddr_o(x_awaddr), .m_awlen_o(x_awlen),
    .m_wvalid_o(x_wvalid), .m_wready_i(1'b0), .m_wdata_o(x_wdata), .m_wstrb_o(x_wstrb),
    .m_wlast_o(x_wlast), .m_bvalid_i(1'b0), .m_bready_o(x_bready)
  );

  // Slave models: decide handshakes mid-cycle, they complete on the next rising edge.
  initial begin
    for (int u = 0; u < 2; u++) begin
      rem[u] = 0; beat[u] = 0; ar_cnt[u] = 0; last_araddr[u] = '0; last_arlen[u] = '0;
      arready[u] = 1'b0; rvalid[u] = 1'b0; rdata[u] = '0; rlast[u] = 1'b0;
      for (int k = 0; k < NR; k++) rd_done_cnt[u][k] = 0;
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int u = 0; u < 2; u++) begin
          rem[u] = 0; rvalid[u] = 1'b0; rlast[u] = 1'b0;
        end
        b_pending = 1'b0; bvalid = 1'b0; w_tog = 1'b0;
      end else begin
        for (int u = 0; u < 2; u++) begin
          rvalid[u] = (rem[u] > 0);
          rdata[u]  = rd_base + 32'(beat[u]);
          rlast[u]  = (rem[u] == 1);
          if (rvalid[u] && rready[u]) begin rem[u]--; beat[u]++; end
          arready[u] = ar_en;
          if (arvalid[u] && arready[u]) begin
            ar_cnt[u]++; last_araddr[u] = araddr[u]; last_arlen[u] = arlen[u];
            rem[u] = int'(arlen[u]) + 1; beat[u] = 0;
          end
          for (int k = 0; k < NR; k++) if (rd_done[u][k]) rd_done_cnt[u][k]++;
        end
        bvalid  = b_pending && b_en;
        awready = aw_en;
        wready  = w_alt ? w_tog : 1'b1;
        w_tog   = ~w_tog;
        if (awvalid && awready) begin aw_cnt++; last_awaddr = awaddr; last_awlen = awlen; end
        if (wvalid && wready) begin
          if (w_beats < 16) begin
            wb_data[w_beats] = wdata; wb_strb[w_beats] = wstrb; wb_last[w_beats] = wlast;
          end
          w_beats++;
          if (wlast) b_pending = 1'b1;
        end
        if (bvalid && bready) begin b_pending = 1'b0; b_cnt++; end
        if (wr_done) wr_done_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int u, input int max, output int cyc, output logic [NR-1:0] vec);
    cyc = 0; vec = '0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (rd_done[u] != 0) begin cyc = i; vec = rd_done[u]; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++;
    if ({arvalid[0], rready[0], awvalid, wvalid, bready, wr_done, wr_busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
                         {arvalid[0], rready[0], awvalid, wvalid, bready, wr_done, wr_busy});
    end
    checks++;
    if (rd_done[0] !== 4'b0) begin errors++; $display("FAIL reset_done: got %b expected 0000", rd_done[0]); end
    checks++;
    if (rd_data[0] !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd_data[0]); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_line_read;
    int cyc, ar0, d0;
    logic [NR-1:0] vec;
    rd_base = 32'h0;
    ar0 = ar_cnt[0]; d0 = rd_done_cnt[0][0];
    rd_addr[31:0] = 32'h1C00_0014; rd_single[0] = 1'b0; rd_req[0] = 1'b1;
    wait_done(0, 40, cyc, vec);
    rd_req[0] = 1'b0;
    checks++;
    if (vec !== 4'b0001) begin errors++; $display("FAIL line_done_vec: got %b expected 0001", vec); end
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL line_latency: got %0d expected 10", cyc); end
    checks++;
    if (last_araddr[0] !== 32'h1C00_0000) begin errors++; $display("FAIL line_araddr: got %h expected 1c000000", last_araddr[0]); end
    checks++;
    if (last_arlen[0] !== 8'd7) begin errors++; $display("FAIL line_arlen: got %0d expected 7", last_arlen[0]); end
    for (int k = 0; k < LW; k++) begin
      checks++;
      if (rd_data[0][32*k +: 32] !== 32'(k)) begin
        errors++; $display("FAIL line_word%0d: got %h expected %h", k, rd_data[0][32*k +: 32], 32'(k));
      end
    end
    tick(5);
    checks++;
    if (rd_done_cnt[0][0] - d0 != 1) begin errors++; $display("FAIL line_done_once: got %0d expected 1", rd_done_cnt[0][0] - d0); end
    checks++;
    if (ar_cnt[0] - ar0 != 1) begin errors++; $display("FAIL line_ar_once: got %0d expected 1", ar_cnt[0] - ar0); end
  endtask

  task automatic test_single_read;
    int cyc;
    logic [NR-1:0] vec;
    rd_base = 32'hCAFE_0000;
    rd_addr[127:96] = 32'hBFAF_8004; rd_single[3] = 1'b1; rd_req[3] = 1'b1;
    wait_done(0, 40, cyc, vec);
    rd_req[3] = 1'b0; rd_single[3] = 1'b0;
    checks++;
    if (vec !== 4'b1000) begin errors++; $display("FAIL single_done_vec: got %b expected 1000", vec); end
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", cyc); end
    checks++;
    if (last_araddr[0] !== 32'hBFAF_8004) begin errors++; $display("FAIL single_araddr: got %h expected bfaf8004", last_araddr[0]); end
    checks++;
    if (last_arlen[0] !== 8'd0) begin errors++; $display("FAIL single_arlen: got %0d expected 0", last_arlen[0]); end
    checks++;
    if (rd_data[0][31:0] !== 32'hCAFE_0000) begin errors++; $display("FAIL single_word0: got %h expected cafe0000", rd_data[0][31:0]); end
    checks++;
    if (rd_data[0][63:32] !== 32'h1) begin errors++; $display("FAIL single_word1_kept: got %h expected 00000001", rd_data[0][63:32]); end
    tick(3);
  endtask

  task automatic test_arbitration;
    logic [NR-1:0] log0 [3];
    logic [NR-1:0] log1 [3];
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 3; i++) begin log0[i] = '0; log1[i] = '0; end
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    rd_base = 32'h10;
    rd_addr[63:32] = 32'h0000_0100; rd_addr[95:64] = 32'h0000_0200;
    rd_req[2:1] = 2'b11;
    for (int i = 0; i < 200 && (n0 < 3 || n1 < 3); i++) begin
      @(posedge clk); #1;
      if (rd_done[0] != 0 && n0 < 3) begin log0[n0] = rd_done[0]; n0++; end
      if (rd_done[1] != 0 && n1 < 3) begin log1[n1] = rd_done[1]; n1++; end
    end
    rd_req[2:1] = 2'b00;
    tick(30);
    checks++;
    if (n0 != 3 || n1 != 3) begin errors++; $display("FAIL arb_timeout: got %0d/%0d grants expected 3/3", n0, n1); end
    checks++;
    if (log0[0] !== 4'b0010) begin errors++; $display("FAIL arb_fixed_g0: got %b expected 0010", log0[0]); end
    checks++;
    if (log0[1] !== 4'b0010) begin errors++; $display("FAIL arb_fixed_g1: got %b expected 0010", log0[1]); end
    checks++;
    if (log1[0] !== 4'b0010) begin errors++; $display("FAIL arb_rr_g0: got %b expected 0010", log1[0]); end
    checks++;
    if (log1[1] !== 4'b0100) begin errors++; $display("FAIL arb_rr_g1: got %b expected 0100", log1[1]); end
    checks++;
    if (log1[2] !== 4'b0010) begin errors++; $display("FAIL arb_rr_g2: got %b expected 0010", log1[2]); end
  endtask

  task automatic test_line_write;
    int b0;
    logic found;
    found = 1'b0;
    b0 = wr_done_cnt;
    w_beats = 0; w_alt = 1'b1;
    wr_addr = 32'h0000_1000; wr_single = 1'b0; wr_strb = 4'h0;
    for (int k = 0; k < LW; k++) wr_data[32*k +: 32] = 32'h1111_0000 + 32'(k);
    wr_req = 1'b1; tick(1); wr_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (wr_done) begin found = 1'b1; break; end
    end
    w_alt = 1'b0;
    tick(4);
    checks++;
    if (!found) begin errors++; $display("FAIL write_timeout: got no wr_done expected one"); end
    checks++;
    if (last_awaddr !== 32'h0000_1000 || last_awlen !== 8'd7) begin
      errors++; $display("FAIL write_aw: got %h/%0d expected 00001000/7", last_awaddr, last_awlen);
    end
    checks++;
    if (w_beats != 8) begin errors++; $display("FAIL write_beats: got %0d expected 8", w_beats); end
    for (int k = 0; k < LW; k++) begin
      checks++;
      if ({wb_data[k], wb_strb[k], wb_last[k]} !== {32'h1111_0000 + 32'(k), 4'hF, (k == 7)}) begin
        errors++; $display("FAIL write_beat%0d: got %h/%h/%b expected %h/f/%b",
                           k, wb_data[k], wb_strb[k], wb_last[k], 32'h1111_0000 + 32'(k), (k == 7));
      end
    end
    checks++;
    if (wr_done_cnt - b0 != 1) begin errors++; $display("FAIL write_done_once: got %0d expected 1", wr_done_cnt - b0); end
  endtask

  task automatic test_hazard;
    int ar0, d0, cyc;
    logic [NR-1:0] vec;
    logic found;
    found = 1'b0;
    b_en = 1'b0; w_beats = 0;
    wr_addr = 32'h0000_1000; wr_single = 1'b0;
    wr_req = 1'b1; tick(1); wr_req = 1'b0;
    for (int i = 0; i < 40 && w_beats < 8; i++) tick(1);
    tick(2);
    checks++;
    if (wr_busy !== 1'b1 || bready !== 1'b1) begin errors++; $display("FAIL hazard_in_wb: got busy=%b bready=%b expected 1/1", wr_busy, bready); end
    ar0 = ar_cnt[0]; d0 = rd_done_cnt[0][0];
    rd_base = 32'h20;
    rd_addr[31:0] = 32'h0000_1004; rd_single[0] = 1'b0; rd_req[0] = 1'b1;
    tick(10);
    checks++;
    if (ar_cnt[0] != ar0) begin errors++; $display("FAIL hazard_blocked: got %0d ARs expected 0", ar_cnt[0] - ar0); end
    rd_addr[63:32] = 32'h0000_2000; rd_req[1] = 1'b1;
    wait_done(0, 40, cyc, vec);
    rd_req[1] = 1'b0;
    checks++;
    if (vec !== 4'b0010) begin errors++; $display("FAIL hazard_other_port: got %b expected 0010", vec); end
    checks++;
    if (last_araddr[0] !== 32'h0000_2000) begin errors++; $display("FAIL hazard_other_addr: got %h expected 00002000", last_araddr[0]); end
    tick(5);
    checks++;
    if (rd_done_cnt[0][0] != d0 || ar_cnt[0] != ar0 + 1) begin
      errors++; $display("FAIL hazard_still_blocked: got done=%0d ar=%0d expected 0/1", rd_done_cnt[0][0] - d0, ar_cnt[0] - ar0);
    end
    b_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wr_done) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || ar_cnt[0] != ar0 + 1) begin
      errors++; $display("FAIL hazard_release: got done=%b ar=%0d expected 1/1", found, ar_cnt[0] - ar0);
    end
    wait_done(0, 40, cyc, vec);
    rd_req[0] = 1'b0;
    checks++;
    if (vec !== 4'b0001 || last_araddr[0] !== 32'h0000_1000) begin
      errors++; $display("FAIL hazard_late_read: got %b/%h expected 0001/00001000", vec, last_araddr[0]);
    end
    tick(3);
  endtask

  task automatic test_reset_busy;
    ar_en = 1'b0; aw_en = 1'b0;
    rd_addr[95:64] = 32'h0000_3000; rd_req[2] = 1'b1;
    wr_addr = 32'h0000_4000; wr_req = 1'b1; tick(1); wr_req = 1'b0;
    tick(3);
    checks++;
    if ({arvalid[0], awvalid, wr_busy, (rd_data[0] != '0)} !== 4'b1111) begin
      errors++; $display("FAIL busy_setup: got %b expected 1111", {arvalid[0], awvalid, wr_busy, (rd_data[0] != '0)});
    end
    rst = 1'b1; rd_req = '0;
    tick(1);
    checks++;
    if ({arvalid[0], rready[0], awvalid, wvalid, bready} !== 5'b0) begin
      errors++; $display("FAIL busy_rst_ctrl: got %b expected 00000", {arvalid[0], rready[0], awvalid, wvalid, bready});
    end
    checks++;
    if ({rd_done[0], wr_done, wr_busy} !== 6'b0) begin
      errors++; $display("FAIL busy_rst_done: got %b expected 000000", {rd_done[0], wr_done, wr_busy});
    end
    checks++;
    if (rd_data[0] !== '0) begin errors++; $display("FAIL busy_rst_data: got %h expected 0", rd_data[0]); end
    ar_en = 1'b1; aw_en = 1'b1;
    tick(2); rst = 1'b0; tick(2);
  endtask

  initial begin
    test_reset();
    test_line_read();
    test_single_read();
    test_arbitration();
    test_line_write();
    test_hazard();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
